pea_result_reader: RTL and testbench

- Consumer end of the PEA output path: drains the result FIFO and status FIFO (both written together by PEA wr_out) in lockstep.
- Presents each {result, status} pair to a host on a valid/ready port.
- Counts delivered pairs and error statuses, and flags FIFO desynchronisation.
- Sits between out_fifo_result / out_fifo_status and host/readback logic; replaces bench-driven rd_en_result / rd_en_status.

---
 rtl/pea_result_reader.sv | 205 ++++++++++++++++++++
 tb/tb_pea_result_reader.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pea_result_reader.sv
// ---------------------------------------------------------------------------
// pea_result_reader
//
// Consumer end of the PEA output path. The result FIFO and the status FIFO
// are written together by the PEA, so they are drained in lockstep: one
// READ cycle pops both, the next cycle captures both read words, and the
// {result, status} pair is then held on a valid/ready port until the host
// takes it. Accepted pairs and pairs carrying a nonzero status are counted.
// A monitor watches the two FIFO populations and raises a sticky flag when
// they disagree for too long, which also freezes further draining.
//
// Ports
//   clk               clock
//   rst               synchronous active-high reset
//   drain_en          permits new FIFO reads (an in-flight pair completes)
//   result_pop        result FIFO population
//   status_pop        status FIFO population
//   fifo_result_data  result FIFO read data, valid the cycle after the pop
//   fifo_status_data  status FIFO read data, valid the cycle after the pop
//   rd_en_result      result FIFO pop strobe
//   rd_en_status      status FIFO pop strobe
//   out_valid         a pair is held on out_result / out_status
//   out_ready         host accepts the pair
//   out_result        delivered result word
//   out_status        delivered status word
//   out_error         delivered status is nonzero (qualified by out_valid)
//   pair_count        pairs accepted by the host, wraps at 0xFFFF
//   err_count         accepted pairs with nonzero status, saturates at 0xFFFF
//   desync_err        sticky FIFO population mismatch flag
//   busy              reader is not idle
// ---------------------------------------------------------------------------
module pea_result_reader #(
   parameter int WIDTH           = 32,
   parameter int BUFFER_SIZE_OUT = 32,
   parameter int POP_W           = $clog2(BUFFER_SIZE_OUT),
   parameter int DESYNC_LIMIT    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             drain_en,
   input  logic [POP_W-1:0] result_pop,
   input  logic [POP_W-1:0] status_pop,
   input  logic [WIDTH-1:0] fifo_result_data,
   input  logic [WIDTH-1:0] fifo_status_data,
   output logic             rd_en_result,
   output logic             rd_en_status,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [WIDTH-1:0] out_status,
   output logic             out_error,
   output logic [15:0]      pair_count,
   output logic [15:0]      err_count,
   output logic             desync_err,
   output logic             busy
);

   localparam int               MIS_W     = $clog2(DESYNC_LIMIT + 1);
   localparam logic [MIS_W-1:0] MIS_LIMIT = MIS_W'(DESYNC_LIMIT);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_READ    = 2'd1,
      S_CAPTURE = 2'd2,
      S_HOLD    = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_next;

   logic [WIDTH-1:0] r_out_result;
   logic [WIDTH-1:0] r_out_status;
   logic [15:0]      r_pair_count;
   logic [15:0]      r_err_count;
   logic [MIS_W-1:0] r_mis_cnt;
   logic [MIS_W-1:0] w_mis_next;
   logic             r_desync_err;

   logic             w_pops_ready;
   logic             w_pop_mismatch;
   logic             w_accept;
   logic             w_status_err;

   // Both FIFOs must hold data before a read starts; one nonempty FIFO alone
   // never triggers a pop.
   assign w_pops_ready   = (result_pop != '0) && (status_pop != '0);
   assign w_pop_mismatch = (result_pop != status_pop);
   assign w_accept       = (r_state == S_HOLD) && out_ready;
   assign w_status_err   = (r_out_status != '0);

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register in the design samples pre-edge values.
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: default first so every path assigns w_state_next and no latch
      // is inferred.
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            // A raised desync flag freezes draining until reset.
            if (drain_en && w_pops_ready && !r_desync_err) begin
               w_state_next = S_READ;
            end
         end
         S_READ:    w_state_next = S_CAPTURE;
         S_CAPTURE: w_state_next = S_HOLD;
         S_HOLD: begin
            // drain_en is deliberately ignored here: a captured pair is
            // always offered until the host takes it.
            if (out_ready) begin
               w_state_next = S_IDLE;
            end
         end
         default:   w_state_next = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Output logic
   // ------------------------------------------------------------------------
   always_comb begin
      rd_en_result = 1'b0;
      rd_en_status = 1'b0;
      out_valid    = 1'b0;
      busy         = (r_state != S_IDLE);
      // A reset arriving during READ must not pop the FIFOs on that cycle.
      if ((r_state == S_READ) && !rst) begin
         rd_en_result = 1'b1;
         rd_en_status = 1'b1;
      end
      if (r_state == S_HOLD) begin
         out_valid = 1'b1;
      end
      out_error = out_valid && w_status_err;
   end

   assign out_result = r_out_result;
   assign out_status = r_out_status;
   assign pair_count = r_pair_count;
   assign err_count  = r_err_count;
   assign desync_err = r_desync_err;

   // ------------------------------------------------------------------------
   // Pair capture and delivery counters
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_result <= '0;
         r_out_status <= '0;
         r_pair_count <= '0;
         r_err_count  <= '0;
      end else begin
         // FIFO read data is valid the cycle after the pop, i.e. in CAPTURE.
         if (r_state == S_CAPTURE) begin
            r_out_result <= fifo_result_data;
            r_out_status <= fifo_status_data;
         end
         if (w_accept) begin
            // pair_count wraps naturally; err_count holds at all-ones.
            r_pair_count <= r_pair_count + 16'd1;
            if (w_status_err && (r_err_count != 16'hFFFF)) begin
               r_err_count <= r_err_count + 16'd1;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Desync monitor: consecutive cycles of unequal populations
   // ------------------------------------------------------------------------
   always_comb begin
      w_mis_next = '0;
      if (w_pop_mismatch) begin
         w_mis_next = (r_mis_cnt == MIS_LIMIT) ? r_mis_cnt : r_mis_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mis_cnt    <= '0;
         r_desync_err <= 1'b0;
      end else begin
         r_mis_cnt <= w_mis_next;
         // The flag rises on the same edge the count reaches the limit and
         // then stays set until reset.
         if (w_mis_next == MIS_LIMIT) begin
            r_desync_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pea_result_reader.sv
`timescale 1ns/1ps
module tb_pea_result_reader;

   localparam int WIDTH = 32;
   localparam int POP_W = 5;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             drain_en = 1'b0;
   logic [POP_W-1:0] result_pop;
   logic [POP_W-1:0] status_pop;
   logic [WIDTH-1:0] fifo_result_data = '0;
   logic [WIDTH-1:0] fifo_status_data = '0;
   logic             rd_en_result;
   logic             rd_en_status;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_result;
   logic [WIDTH-1:0] out_status;
   logic             out_error;
   logic [15:0]      pair_count;
   logic [15:0]      err_count;
   logic             desync_err;
   logic             busy;

   pea_result_reader #(
      .WIDTH           (WIDTH),
      .BUFFER_SIZE_OUT (32),
      .POP_W           (POP_W),
      .DESYNC_LIMIT    (8)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .drain_en         (drain_en),
      .result_pop       (result_pop),
      .status_pop       (status_pop),
      .fifo_result_data (fifo_result_data),
      .fifo_status_data (fifo_status_data),
      .rd_en_result     (rd_en_result),
      .rd_en_status     (rd_en_status),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_result       (out_result),
      .out_status       (out_status),
      .out_error        (out_error),
      .pair_count       (pair_count),
      .err_count        (err_count),
      .desync_err       (desync_err),
      .busy             (busy)
   );

   always #5 clk = ~clk;

   // ---------------- FIFO model (read data registered on the pop edge) -----
   logic [WIDTH-1:0] res_mem [64];
   logic [WIDTH-1:0] sts_mem [64];
   int               wp = 0;
   int               rp_res = 0;
   int               rp_sts = 0;
   logic             pop_ovr = 1'b0;
   logic [POP_W-1:0] ovr_res_pop = '0;
   logic [POP_W-1:0] ovr_sts_pop = '0;

   assign result_pop = pop_ovr ? ovr_res_pop : POP_W'(wp - rp_res);
   assign status_pop = pop_ovr ? ovr_sts_pop : POP_W'(wp - rp_sts);

   always @(posedge clk) begin
      if (rd_en_result) begin
         fifo_result_data <= res_mem[6'(rp_res)];
         rp_res           <= rp_res + 1;
      end
      if (rd_en_status) begin
         fifo_status_data <= sts_mem[6'(rp_sts)];
         rp_sts           <= rp_sts + 1;
      end
   end

   // ---------------- protocol monitor (samples on the falling edge) --------
   int               rd_cnt = 0;
   int               rd_pair_viol = 0;
   int               rd_len_viol = 0;
   int               stab_viol = 0;
   logic             prev_rd = 1'b0;
   logic             prev_valid = 1'b0;
   logic             prev_acc = 1'b0;
   logic             prev_rst = 1'b1;
   logic [WIDTH-1:0] prev_res = '0;
   logic [WIDTH-1:0] prev_sts = '0;

   always @(negedge clk) begin
      if (rd_en_result === 1'b1) rd_cnt <= rd_cnt + 1;
      if (rd_en_result !== rd_en_status) rd_pair_viol <= rd_pair_viol + 1;
      if (rd_en_result === 1'b1 && prev_rd) rd_len_viol <= rd_len_viol + 1;
      if (prev_valid && !prev_acc && !prev_rst &&
          (out_valid !== 1'b1 || out_result !== prev_res || out_status !== prev_sts))
         stab_viol <= stab_viol + 1;
      prev_rd    <= (rd_en_result === 1'b1);
      prev_valid <= (out_valid === 1'b1);
      prev_acc   <= (out_valid === 1'b1) && out_ready;
      prev_rst   <= rst;
      prev_res   <= out_result;
      prev_sts   <= out_status;
   end

   // ---------------- scoreboard and reference counters ----------------------
   logic [63:0] exp_q [$];
   logic [15:0] exp_pairs = '0;
   logic [15:0] exp_errs = '0;
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_pair(input logic [31:0] r, input logic [31:0] s);
      res_mem[6'(wp)] = r;
      sts_mem[6'(wp)] = s;
      wp = wp + 1;
      exp_q.push_back({r, s});
   endtask

   task automatic model_accept(input logic [63:0] p);
      exp_pairs = exp_pairs + 16'd1;
      if (p[31:0] != 32'd0 && exp_errs != 16'hFFFF) exp_errs = exp_errs + 16'd1;
   endtask

   task automatic wait_valid(output bit ok, output int cyc);
      ok  = 1'b0;
      cyc = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         cyc++;
         if (out_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------------------------------------------
   task automatic test_reset();
      int r0;
      rst = 1'b1; drain_en = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({out_valid, rd_en_result, rd_en_status, out_error, desync_err, busy} !== 6'b0) begin
         n_errors++;
         $display("FAIL reset_flags: got %b expected 000000",
                  {out_valid, rd_en_result, rd_en_status, out_error, desync_err, busy});
      end
      n_checks++;
      if ({out_result, out_status} !== 64'd0) begin
         n_errors++;
         $display("FAIL reset_data: got %h expected 0", {out_result, out_status});
      end
      n_checks++;
      if ({pair_count, err_count} !== 32'd0) begin
         n_errors++;
         $display("FAIL reset_counts: got %h expected 0", {pair_count, err_count});
      end
      tick();
      drain_en = 1'b1; out_ready = 1'b1;
      r0 = rd_cnt;
      repeat (20) tick();
      n_checks++;
      if (rd_cnt !== r0 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL idle_no_read: got %0d reads busy=%b expected 0 reads busy=0", rd_cnt - r0, busy);
      end
   endtask

   task automatic test_single();
      logic [63:0] p;
      push_pair(32'h0000_00A5, 32'h0);
      @(negedge clk);
      n_checks++;
      if (rd_en_result !== 1'b0 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL single_idle: got rd=%b busy=%b expected 0 0", rd_en_result, busy);
      end
      @(negedge clk);
      n_checks++;
      if (rd_en_result !== 1'b1 || rd_en_status !== 1'b1 || out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL single_read: got rd=%b%b valid=%b expected 11 0", rd_en_result, rd_en_status, out_valid);
      end
      @(negedge clk);
      n_checks++;
      if (rd_en_result !== 1'b0 || out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL single_capture: got rd=%b valid=%b expected 0 0", rd_en_result, out_valid);
      end
      @(negedge clk);
      p = exp_q.pop_front();
      n_checks++;
      if (out_valid !== 1'b1 || {out_result, out_status} !== p || out_error !== 1'b0) begin
         n_errors++;
         $display("FAIL single_hold: got v=%b pair=%h err=%b expected 1 %h 0", out_valid, {out_result, out_status}, out_error, p);
      end
      model_accept(p);
      tick();
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || pair_count !== exp_pairs || err_count !== exp_errs) begin
         n_errors++;
         $display("FAIL single_counts: got v=%b pc=%0d ec=%0d expected 0 %0d %0d", out_valid, pair_count, err_count, exp_pairs, exp_errs);
      end
      tick();
   endtask

   task automatic test_backpressure();
      logic [63:0] p;
      bit ok;
      int cyc;
      int r0;
      out_ready = 1'b0;
      r0 = rd_cnt;
      push_pair(32'h1111_0001, 32'h0);
      push_pair(32'h2222_0002, 32'h1);
      push_pair(32'h3333_0003, 32'h0);
      for (int k = 0; k < 3; k++) begin
         wait_valid(ok, cyc);
         n_checks++;
         if (!ok) begin
            n_errors++;
            $display("FAIL bp_timeout%0d: got no out_valid in %0d cycles expected valid", k, cyc);
         end
         p = exp_q.pop_front();
         repeat (10) @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b1 || {out_result, out_status} !== p || out_error !== (p[31:0] != 32'd0)) begin
            n_errors++;
            $display("FAIL bp_pair%0d: got v=%b pair=%h err=%b expected 1 %h %b", k, out_valid,
                     {out_result, out_status}, out_error, p, (p[31:0] != 32'd0));
         end
         tick();
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         model_accept(p);
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b0 || out_error !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_drop%0d: got v=%b err=%b expected 0 0", k, out_valid, out_error);
         end
      end
      tick();
      n_checks++;
      if (rd_cnt - r0 !== 3 || pair_count !== exp_pairs || err_count !== exp_errs) begin
         n_errors++;
         $display("FAIL bp_totals: got reads=%0d pc=%0d ec=%0d expected 3 %0d %0d", rd_cnt - r0, pair_count, err_count, exp_pairs, exp_errs);
      end
   endtask

   task automatic test_empty_boundary();
      int r0;
      drain_en = 1'b1; out_ready = 1'b1;
      r0 = rd_cnt;
      pop_ovr = 1'b1; ovr_res_pop = 5'd31; ovr_sts_pop = 5'd0;
      repeat (7) tick();
      ovr_res_pop = 5'd0;
      repeat (2) tick();
      ovr_sts_pop = 5'd31;
      repeat (7) tick();
      ovr_sts_pop = 5'd0;
      tick();
      pop_ovr = 1'b0;
      tick();
      n_checks++;
      if (rd_cnt !== r0 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL one_empty: got %0d reads busy=%b expected 0 reads busy=0", rd_cnt - r0, busy);
      end
      n_checks++;
      if (desync_err !== 1'b0) begin
         n_errors++;
         $display("FAIL desync_below_limit: got %b expected 0", desync_err);
      end
   endtask

   task automatic test_desync();
      int r0;
      drain_en = 1'b0;
      r0 = rd_cnt;
      pop_ovr = 1'b1; ovr_res_pop = 5'd2; ovr_sts_pop = 5'd1;
      repeat (7) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (desync_err !== 1'b0) begin
         n_errors++;
         $display("FAIL desync_7: got %b expected 0", desync_err);
      end
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (desync_err !== 1'b1) begin
         n_errors++;
         $display("FAIL desync_8: got %b expected 1", desync_err);
      end
      tick();
      ovr_sts_pop = 5'd2;
      drain_en = 1'b1;
      repeat (20) tick();
      n_checks++;
      if (rd_cnt !== r0 || busy !== 1'b0 || desync_err !== 1'b1) begin
         n_errors++;
         $display("FAIL desync_frozen: got reads=%0d busy=%b flag=%b expected 0 0 1", rd_cnt - r0, busy, desync_err);
      end
      pop_ovr = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [63:0] p;
      bit ok;
      int cyc;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_pairs = '0; exp_errs = '0;
      @(negedge clk);
      n_checks++;
      if (desync_err !== 1'b0 || pair_count !== 16'd0) begin
         n_errors++;
         $display("FAIL rst_clears_desync: got flag=%b pc=%0d expected 0 0", desync_err, pair_count);
      end
      tick();
      drain_en = 1'b1; out_ready = 1'b1;
      push_pair(32'hBEEF_0001, 32'h5);
      push_pair(32'hBEEF_0002, 32'h0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || rd_en_result !== 1'b0 || out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL mid_capture: got busy=%b rd=%b v=%b expected 1 0 0", busy, rd_en_result, out_valid);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || {pair_count, err_count} !== 32'd0 || out_status !== 32'd0) begin
         n_errors++;
         $display("FAIL mid_reset: got v=%b busy=%b counts=%h sts=%h expected 0 0 0 0", out_valid, busy, {pair_count, err_count}, out_status);
      end
      void'(exp_q.pop_front());
      wait_valid(ok, cyc);
      p = exp_q.pop_front();
      n_checks++;
      if (!ok || {out_result, out_status} !== p) begin
         n_errors++;
         $display("FAIL mid_next_pair: got ok=%b pair=%h expected 1 %h", ok, {out_result, out_status}, p);
      end
      model_accept(p);
      tick();
      @(negedge clk);
      n_checks++;
      if (pair_count !== exp_pairs || err_count !== exp_errs) begin
         n_errors++;
         $display("FAIL mid_counts: got pc=%0d ec=%0d expected %0d %0d", pair_count, err_count, exp_pairs, exp_errs);
      end
      tick();
   endtask

   task automatic test_drain_gating();
      logic [63:0] p;
      logic [31:0] sts [4];
      bit ok;
      int cyc;
      int r0;
      sts[0] = 32'h0; sts[1] = 32'h8000_0000; sts[2] = 32'h0; sts[3] = 32'h7;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_pairs = '0; exp_errs = '0;
      drain_en = 1'b0; out_ready = 1'b1;
      r0 = rd_cnt;
      for (int i = 0; i < 4; i++) push_pair(32'hC0DE_0000 + 32'(i), sts[i]);
      repeat (15) tick();
      n_checks++;
      if (rd_cnt !== r0 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL gate_closed: got reads=%0d busy=%b expected 0 0", rd_cnt - r0, busy);
      end
      drain_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_valid(ok, cyc);
         p = exp_q.pop_front();
         n_checks++;
         if (!ok || cyc != 4 || {out_result, out_status} !== p || out_error !== (p[31:0] != 32'd0)) begin
            n_errors++;
            $display("FAIL gate_pair%0d: got ok=%b cycles=%0d pair=%h err=%b expected 1 4 %h %b", i, ok, cyc,
                     {out_result, out_status}, out_error, p, (p[31:0] != 32'd0));
         end
         model_accept(p);
         tick();
      end
      tick();
      n_checks++;
      if (pair_count !== exp_pairs || err_count !== exp_errs || rd_cnt - r0 !== 4) begin
         n_errors++;
         $display("FAIL gate_totals: got pc=%0d ec=%0d reads=%0d expected %0d %0d 4", pair_count, err_count, rd_cnt - r0, exp_pairs, exp_errs);
      end
   endtask

   task automatic test_protocol();
      n_checks++;
      if (rd_pair_viol !== 0 || rd_len_viol !== 0) begin
         n_errors++;
         $display("FAIL rd_strobes: got pair_viol=%0d len_viol=%0d expected 0 0", rd_pair_viol, rd_len_viol);
      end
      n_checks++;
      if (stab_viol !== 0) begin
         n_errors++;
         $display("FAIL hold_stable: got %0d violations expected 0", stab_viol);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_empty_boundary();
      test_desync();
      test_reset_mid();
      test_drain_gating();
      test_protocol();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
